// File: rtl/alu_accum_param_if.sv
// Operand/result bus of the accumulating ALU.
// The master drives operation requests; the slave (the ALU) returns the
// accumulator, flags and handshake status.
interface alu_accum_param_if #(
   parameter int WIDTH = 8
);
   logic             In_valid;
   logic             In_ready;
   logic [2:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Use_acc;
   logic [WIDTH-1:0] R;
   logic             Cout;
   logic             Of;
   logic             Zero;
   logic             Neg;
   logic             Out_valid;
   logic             Busy;

   modport master (
      output In_valid, Op, A, B, Cin, Use_acc,
      input  In_ready, R, Cout, Of, Zero, Neg, Out_valid, Busy
   );

   modport slave (
      input  In_valid, Op, A, B, Cin, Use_acc,
      output In_ready, R, Cout, Of, Zero, Neg, Out_valid, Busy
   );
endinterface

// File: rtl/alu_accum_param.sv
// Parametrised accumulating ALU with registered flags, valid/ready input
// handshake, accumulator feedback on B and a WIDTH-cycle shift-add multiply.
// Optional macro ALU_ACCUM_SATURATE_EN: unsigned saturation of ADD/SUB/MUL.
module alu_accum_param #(
   parameter int WIDTH = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   alu_accum_param_if.slave  bus
);

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_CMP  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_PASS = 3'd6;
   localparam logic [2:0] OP_MUL  = 3'd7;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     r_q, r_d;
   logic                 cout_q, cout_d;
   logic                 of_q, of_d;
   logic                 zero_q, zero_d;
   logic                 neg_q, neg_d;
   logic                 ovalid_q, ovalid_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic                 accept;
   logic                 last_step;
   logic [WIDTH-1:0]     bop;
   logic [WIDTH:0]       sum_w;
   logic [WIDTH:0]       dif_w;
   logic [2*WIDTH-1:0]   prod_step;
   logic [WIDTH-1:0]     res;

   assign accept    = bus.In_valid && (state_q == IDLE);
   assign last_step = (cnt_q == CW'(WIDTH - 1));
   assign bop       = bus.Use_acc ? r_q : bus.B;
   assign sum_w     = {1'b0, bus.A} + {1'b0, bop} + {{WIDTH{1'b0}}, bus.Cin};
   assign dif_w     = {1'b0, bus.A} - {1'b0, bop} - {{WIDTH{1'b0}}, bus.Cin};
   assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

   // State and datapath registers; reset aborts any multiply in flight
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         r_q      <= '0;
         cout_q   <= 1'b0;
         of_q     <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovalid_q <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         cout_q   <= cout_d;
         of_q     <= of_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ovalid_q <= ovalid_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next state: enter MUL on an accepted multiply, leave after WIDTH steps
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && bus.Op == OP_MUL) state_d = MUL;
         MUL:     if (last_step) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Result, flags and multiplier datapath updates
   always_comb begin
      r_d      = r_q;
      cout_d   = cout_q;
      of_d     = of_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      ovalid_d = 1'b0;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      res      = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (bus.Op)
                  OP_ADD: begin
                     res    = sum_w[WIDTH-1:0];
                     cout_d = sum_w[WIDTH];
                     of_d   = (bus.A[WIDTH-1] == bop[WIDTH-1]) &&
                              (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
`ifdef ALU_ACCUM_SATURATE_EN
                     if (sum_w[WIDTH]) res = '1;
`endif
                  end
                  OP_SUB, OP_CMP: begin
                     res    = dif_w[WIDTH-1:0];
                     cout_d = dif_w[WIDTH];
                     of_d   = (bus.A[WIDTH-1] != bop[WIDTH-1]) &&
                              (dif_w[WIDTH-1] != bus.A[WIDTH-1]);
`ifdef ALU_ACCUM_SATURATE_EN
                     if (bus.Op == OP_SUB && dif_w[WIDTH]) res = '0;
`endif
                  end
                  OP_AND: begin
                     res    = bus.A & bop;
                     cout_d = 1'b0;
                     of_d   = 1'b0;
                  end
                  OP_OR: begin
                     res    = bus.A | bop;
                     cout_d = 1'b0;
                     of_d   = 1'b0;
                  end
                  OP_XOR: begin
                     res    = bus.A ^ bop;
                     cout_d = 1'b0;
                     of_d   = 1'b0;
                  end
                  OP_PASS: begin
                     res    = bus.A;
                     cout_d = 1'b0;
                     of_d   = 1'b0;
                  end
                  default: begin
                     res = r_q;
                  end
               endcase
               if (bus.Op == OP_MUL) begin
                  mcand_d  = {{WIDTH{1'b0}}, bus.A};
                  mplier_d = bop;
                  prod_d   = '0;
                  cnt_d    = '0;
               end else begin
                  // CMP flags come from the difference, R is left alone
                  if (bus.Op != OP_CMP) r_d = res;
                  zero_d   = (res == '0);
                  neg_d    = res[WIDTH-1];
                  ovalid_d = 1'b1;
               end
            end
         end
         MUL: begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_step) begin
               // The final step's sum is used directly so R lands at edge k+WIDTH
               res    = prod_step[WIDTH-1:0];
               of_d   = |prod_step[2*WIDTH-1:WIDTH];
               cout_d = 1'b0;
`ifdef ALU_ACCUM_SATURATE_EN
               if (|prod_step[2*WIDTH-1:WIDTH]) res = '1;
`endif
               r_d      = res;
               zero_d   = (res == '0);
               neg_d    = res[WIDTH-1];
               ovalid_d = 1'b1;
            end
         end
         default: begin
            ovalid_d = 1'b0;
         end
      endcase
   end

   assign bus.In_ready  = (state_q == IDLE);
   assign bus.Busy      = (state_q != IDLE);
   assign bus.R         = r_q;
   assign bus.Cout      = cout_q;
   assign bus.Of        = of_q;
   assign bus.Zero      = zero_q;
   assign bus.Neg       = neg_q;
   assign bus.Out_valid = ovalid_q;

endmodule

// File: tb/tb_alu_accum_param.sv
// Testbench for alu_accum_param at WIDTH=4: directed plan items plus
// randomized operations checked against an integer-arithmetic model.
module tb_alu_accum_param;

   localparam int W = 4;
   localparam int M = 1 << W;
   localparam int HALF = M / 2;

   logic Clk = 1'b0;
   logic Reset = 1'b0;

   int passed = 0;
   int total  = 0;

   // reference model state
   int m_r = 0;
   bit m_c = 0, m_o = 0, m_z = 0, m_n = 0;

   alu_accum_param_if #(.WIDTH(W)) bus ();

   alu_accum_param #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   function automatic int sgn(input int v);
      return (v >= HALF) ? v - M : v;
   endfunction

   // Reference: results from plain integer arithmetic on the operation rules
   task automatic model_exec(input int op, input int a, input int bop, input int cin);
      int s, res, sd;
      res = m_r;
      case (op)
         0: begin
            s = a + bop + cin; m_c = (s >= M); res = s % M;
            sd = sgn(a) + sgn(bop) + cin; m_o = (sd >= HALF) || (sd < -HALF);
`ifdef ALU_ACCUM_SATURATE_EN
            if (m_c) res = M - 1;
`endif
         end
         1, 2: begin
            s = a - bop - cin; m_c = (s < 0); res = (s + 2 * M) % M;
            sd = sgn(a) - sgn(bop) - cin; m_o = (sd >= HALF) || (sd < -HALF);
`ifdef ALU_ACCUM_SATURATE_EN
            if (op == 1 && m_c) res = 0;
`endif
         end
         3: begin res = a & bop; m_c = 0; m_o = 0; end
         4: begin res = a | bop; m_c = 0; m_o = 0; end
         5: begin res = a ^ bop; m_c = 0; m_o = 0; end
         6: begin res = a; m_c = 0; m_o = 0; end
         default: begin
            s = a * bop; m_o = (s >= M); m_c = 0; res = s % M;
`ifdef ALU_ACCUM_SATURATE_EN
            if (m_o) res = M - 1;
`endif
         end
      endcase
      m_z = (res == 0);
      m_n = (res >= HALF);
      if (op != 2) m_r = res;
   endtask

   // Issue one operation; inputs are driven just after an edge and outputs
   // are checked 1 time unit after the edge that completes the operation.
   task automatic do_op(input int op, input int a, input int b, input int cin, input bit ua);
      int bop;
      logic [W+4:0] got, exp;
      bop = ua ? m_r : b;
      bus.In_valid = 1'b1;
      bus.Op = op[2:0];
      bus.A = a[W-1:0];
      bus.B = b[W-1:0];
      bus.Cin = cin[0];
      bus.Use_acc = ua;
      @(posedge Clk); #1;
      if (op == 7) begin
         for (int i = 0; i < W; i++) begin
            total++;
            if (bus.In_ready !== 1'b0 || bus.Busy !== 1'b1 || bus.Out_valid !== 1'b0 || bus.R !== m_r[W-1:0]) begin
               $display("FAIL mul_busy cyc=%0d: ready=%b busy=%b ov=%b R=%h, required ready=0 busy=1 ov=0 R=%h",
                        i, bus.In_ready, bus.Busy, bus.Out_valid, bus.R, m_r[W-1:0]);
            end else passed++;
            // garbage requests while busy must be ignored
            bus.In_valid = 1'b1;
            bus.Op = 3'($urandom_range(0, 7));
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            bus.Use_acc = 1'($urandom);
            bus.Cin = 1'($urandom);
            @(posedge Clk); #1;
         end
         bus.In_valid = 1'b0;
      end
      model_exec(op, a, bop, cin);
      got = {bus.R, bus.Cout, bus.Of, bus.Zero, bus.Neg, bus.Out_valid, bus.In_ready};
      exp = {m_r[W-1:0], m_c, m_o, m_z, m_n, 1'b1, 1'b1};
      total++;
      if (got !== exp)
         $display("FAIL op%0d a=%h b=%h cin=%0d ua=%0d: {R,C,V,Z,N,ov,rdy}=%b required %b",
                  op, a, b, cin, ua, got, exp);
      else passed++;
   endtask

   task automatic idle_cycle();
      bus.In_valid = 1'b0;
      @(posedge Clk); #1;
      total++;
      if (bus.Out_valid !== 1'b0 || bus.In_ready !== 1'b1 || bus.R !== m_r[W-1:0])
         $display("FAIL idle: ov=%b ready=%b R=%h, required ov=0 ready=1 R=%h",
                  bus.Out_valid, bus.In_ready, bus.R, m_r[W-1:0]);
      else passed++;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bus.In_valid = 1'b1;
      bus.Op = 3'd6;
      bus.A = 4'hA;
      bus.B = 4'h3;
      bus.Cin = 1'b1;
      bus.Use_acc = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      total++;
      if ({bus.R, bus.Cout, bus.Of, bus.Zero, bus.Neg, bus.Out_valid, bus.In_ready, bus.Busy} !== {4'h0, 6'b000001, 1'b0})
         $display("FAIL reset: R=%h C=%b V=%b Z=%b N=%b ov=%b ready=%b busy=%b, required all 0 except ready=1",
                  bus.R, bus.Cout, bus.Of, bus.Zero, bus.Neg, bus.Out_valid, bus.In_ready, bus.Busy);
      else passed++;
      Reset = 1'b0;
      bus.In_valid = 1'b0;
      m_r = 0; m_c = 0; m_o = 0; m_z = 0; m_n = 0;
   endtask

   task automatic test_directed();
      // ADD wrap (or saturation)
      do_op(0, 4'hF, 4'h1, 0, 0);
      total++;
`ifdef ALU_ACCUM_SATURATE_EN
      if (bus.R !== 4'hF || bus.Zero !== 1'b0) $display("FAIL add_sat: R=%h Z=%b required R=f Z=0", bus.R, bus.Zero);
`else
      if (bus.R !== 4'h0 || bus.Zero !== 1'b1) $display("FAIL add_wrap: R=%h Z=%b required R=0 Z=1", bus.R, bus.Zero);
`endif
      else passed++;
      idle_cycle();
      // SUB with borrow and signed overflow
      do_op(1, 4'h7, 4'hC, 0, 0);
      idle_cycle();
      // PASS then CMP equal
      do_op(6, 4'h5, 4'h0, 0, 0);
      do_op(2, 4'hA, 4'hA, 0, 0);
      total++;
      if (bus.R !== 4'h5 || bus.Zero !== 1'b1)
         $display("FAIL cmp_hold: R=%h Z=%b required R=5 Z=1", bus.R, bus.Zero);
      else passed++;
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      do_op(6, 4'h3, 4'h0, 0, 0);
      do_op(0, 4'h2, 4'h9, 0, 1);
      do_op(3, 4'h7, 4'h9, 0, 1);
      do_op(5, 4'h5, 4'h9, 0, 1);
      total++;
      if (bus.R !== 4'h0 || bus.Zero !== 1'b1)
         $display("FAIL b2b_acc: R=%h Z=%b required R=0 Z=1", bus.R, bus.Zero);
      else passed++;
      idle_cycle();
   endtask

   task automatic test_mul();
      do_op(7, 4'h5, 4'h3, 0, 0);
      total++;
      if (bus.R !== 4'hF || bus.Of !== 1'b0) $display("FAIL mul_5x3: R=%h V=%b required R=f V=0", bus.R, bus.Of);
      else passed++;
      idle_cycle();
      do_op(7, 4'h6, 4'h3, 0, 0);
      total++;
`ifdef ALU_ACCUM_SATURATE_EN
      if (bus.R !== 4'hF || bus.Of !== 1'b1) $display("FAIL mul_6x3: R=%h V=%b required R=f V=1", bus.R, bus.Of);
`else
      if (bus.R !== 4'h2 || bus.Of !== 1'b1) $display("FAIL mul_6x3: R=%h V=%b required R=2 V=1", bus.R, bus.Of);
`endif
      else passed++;
      idle_cycle();
   endtask

   task automatic test_mul_reset();
      bus.In_valid = 1'b1;
      bus.Op = 3'd7;
      bus.A = 4'h7;
      bus.B = 4'h7;
      bus.Cin = 1'b0;
      bus.Use_acc = 1'b0;
      @(posedge Clk); #1;
      bus.In_valid = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      m_r = 0; m_c = 0; m_o = 0; m_z = 0; m_n = 0;
      total++;
      if ({bus.R, bus.Cout, bus.Of, bus.Zero, bus.Neg, bus.Out_valid, bus.In_ready} !== {4'h0, 6'b000001})
         $display("FAIL mul_reset: R=%h C=%b V=%b Z=%b N=%b ov=%b ready=%b, required all 0 except ready=1",
                  bus.R, bus.Cout, bus.Of, bus.Zero, bus.Neg, bus.Out_valid, bus.In_ready);
      else passed++;
      repeat (W) idle_cycle();
      do_op(0, 4'h1, 4'h1, 0, 0);
      total++;
      if (bus.R !== 4'h2) $display("FAIL post_reset_add: R=%h required 2", bus.R);
      else passed++;
      idle_cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         do_op($urandom_range(0, 7), $urandom_range(0, M - 1), $urandom_range(0, M - 1),
               $urandom_range(0, 1), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();
   endtask

   initial begin
      bus.In_valid = 1'b0;
      bus.Op = 3'd0;
      bus.A = '0;
      bus.B = '0;
      bus.Cin = 1'b0;
      bus.Use_acc = 1'b0;
      #2;
      test_reset();
      test_directed();
      test_back_to_back();
      test_mul();
      test_mul_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
